// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter: start bit, LSB-first payload, configurable stop bits
module uart_tx_core #(
  parameter int CYCLES_PER_BIT = 5000,
  parameter int PAYLOAD_BITS   = 8,
  parameter int STOP_BITS      = 1,
  parameter int COUNT_REG_LEN  = 14
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_tx_busy,
  output logic                    uart_tx_done,
  output logic                    uart_txd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [COUNT_REG_LEN-1:0] LAST_CYC  = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]               LAST_BIT  = 3'(PAYLOAD_BITS - 1);
  localparam logic                     LAST_STOP = 1'(STOP_BITS - 1);

  state_t                    state;
  logic [COUNT_REG_LEN-1:0]  cyc_cnt;
  logic [2:0]                bit_cnt;
  logic                      stop_cnt;
  logic [PAYLOAD_BITS-1:0]   shreg;
  logic                      txd_q;
  logic                      boundary;

  assign boundary     = (cyc_cnt == LAST_CYC);
  assign uart_tx_busy = (state != IDLE);
  assign uart_tx_done = (state == STOP) && boundary && (stop_cnt == LAST_STOP);
  assign uart_txd     = txd_q;

  // txd is registered, so each branch loads the level the line must show in the next state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      txd_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cyc_cnt  <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          txd_q    <= 1'b1;
          if (uart_tx_en) begin
            shreg <= uart_tx_data;
            txd_q <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (boundary) begin
            cyc_cnt <= '0;
            txd_q   <= shreg[0];
            state   <= SEND;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        SEND: begin
          if (boundary) begin
            cyc_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              txd_q   <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              txd_q   <= shreg[1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        STOP: begin
          txd_q <= 1'b1;
          if (boundary) begin
            cyc_cnt <= '0;
            if (stop_cnt == LAST_STOP) begin
              stop_cnt <= 1'b0;
              state    <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed self-checking bench for uart_tx_core
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic       resetn;
  logic       en;
  logic [7:0] data;
  logic       busy1, done1, txd1;
  logic       busy2, done2, txd2;

  int n_cmp = 0;
  int n_err = 0;
  int busy1_cnt = 0;
  int busy2_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_core #(.CYCLES_PER_BIT(4), .PAYLOAD_BITS(8), .STOP_BITS(1), .COUNT_REG_LEN(14)) dut1 (
    .clk(clk), .resetn(resetn), .uart_tx_en(en), .uart_tx_data(data),
    .uart_tx_busy(busy1), .uart_tx_done(done1), .uart_txd(txd1)
  );

  uart_tx_core #(.CYCLES_PER_BIT(4), .PAYLOAD_BITS(8), .STOP_BITS(2), .COUNT_REG_LEN(14)) dut2 (
    .clk(clk), .resetn(resetn), .uart_tx_en(en), .uart_tx_data(data),
    .uart_tx_busy(busy2), .uart_tx_done(done2), .uart_txd(txd2)
  );

  always @(negedge clk) begin
    if (busy1) busy1_cnt = busy1_cnt + 1;
    if (busy2) busy2_cnt = busy2_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit i = expected txd in cycle i after the accept edge, 4 cycles per bit
  function automatic logic [63:0] exp_wave(input logic [7:0] d);
    logic [63:0] w;
    w = '1;
    for (int k = 0; k < 4; k++) w[k] = 1'b0;
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 4; k++) w[4 + 4*b + k] = d[b];
    return w;
  endfunction

  task automatic start(input logic [7:0] d);
    en   = 1'b1;
    data = d;
    @(negedge clk);
  endtask

  // Called at the negedge of cycle 0; returns at the negedge of cycle len
  task automatic capture(input int sel, input int len, input int mode,
                         output logic [63:0] w, output int done_at, output int ndone);
    w = '1;
    done_at = -1;
    ndone = 0;
    for (int i = 0; i < len; i++) begin
      w[i] = (sel != 0) ? txd2 : txd1;
      if ((sel != 0) ? done2 : done1) begin
        ndone++;
        done_at = i;
      end
      case (mode)
        1: begin
          if (i == 0) en = 1'b0;
          if (i == 10) begin en = 1'b1; data = 8'h3C; end
          if (i == 11) en = 1'b0;
        end
        2: begin
          if (i == 0) en = 1'b0;
          data = 8'($urandom);
        end
        3: if (i == 0) data = 8'hFF;
        default: if (i == 0) en = 1'b0;
      endcase
      @(negedge clk);
    end
  endtask

  logic [63:0] w;
  int done_at, ndone;

  initial begin
    resetn = 1'b0;
    en     = 1'b1;
    data   = 8'hAA;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", 64'(txd1), 64'd1);
    check_eq("rst_busy", 64'(busy1), 64'd0);
    check_eq("rst_done", 64'(done1), 64'd0);
    en = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    check_eq("rst_en_ignored", 64'(busy1), 64'd0);

    busy1_cnt = 0;
    start(8'hA5);
    capture(0, 40, 0, w, done_at, ndone);
    check_eq("a5_wave", w, exp_wave(8'hA5));
    check_eq("a5_busy_cycles", 64'(busy1_cnt), 64'd40);
    check_eq("a5_done_count", 64'(ndone), 64'd1);
    check_eq("a5_done_at", 64'(done_at), 64'd39);
    check_eq("a5_idle_txd", 64'(txd1), 64'd1);
    check_eq("a5_idle_busy", 64'(busy1), 64'd0);

    busy1_cnt = 0;
    start(8'h00);
    capture(0, 40, 3, w, done_at, ndone);
    check_eq("b2b_wave0", w, exp_wave(8'h00));
    check_eq("b2b_done0", 64'(done_at), 64'd39);
    check_eq("b2b_accept_cycle_busy", 64'(busy1), 64'd0);
    @(negedge clk);
    check_eq("b2b_second_start", 64'(txd1), 64'd0);
    capture(0, 40, 0, w, done_at, ndone);
    check_eq("b2b_wave1", w, exp_wave(8'hFF));
    check_eq("b2b_done1", 64'(done_at), 64'd39);
    check_eq("b2b_busy_cycles", 64'(busy1_cnt), 64'd80);

    busy1_cnt = 0;
    start(8'hA5);
    capture(0, 40, 1, w, done_at, ndone);
    check_eq("ign_wave", w, exp_wave(8'hA5));
    check_eq("ign_busy_cycles", 64'(busy1_cnt), 64'd40);
    @(negedge clk);
    check_eq("ign_stays_idle", 64'(busy1), 64'd0);
    check_eq("ign_txd_idle", 64'(txd1), 64'd1);

    start(8'hA5);
    capture(0, 17, 0, w, done_at, ndone);
    resetn = 1'b0;
    @(negedge clk);
    check_eq("abort_txd", 64'(txd1), 64'd1);
    check_eq("abort_busy", 64'(busy1), 64'd0);
    check_eq("abort_done", 64'(done1), 64'd0);
    check_eq("abort_no_done_before", 64'(ndone), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    busy1_cnt = 0;
    start(8'h55);
    capture(0, 40, 0, w, done_at, ndone);
    check_eq("post_rst_wave", w, exp_wave(8'h55));
    check_eq("post_rst_busy", 64'(busy1_cnt), 64'd40);

    busy1_cnt = 0;
    start(8'h0F);
    capture(0, 40, 2, w, done_at, ndone);
    check_eq("data_stable_wave", w, exp_wave(8'h0F));
    check_eq("data_stable_done", 64'(done_at), 64'd39);

    @(negedge clk);
    check_eq("two_stop_idle_before", 64'(busy2), 64'd0);
    busy2_cnt = 0;
    start(8'h81);
    capture(1, 44, 0, w, done_at, ndone);
    check_eq("two_stop_wave", w, exp_wave(8'h81));
    check_eq("two_stop_busy", 64'(busy2_cnt), 64'd44);
    check_eq("two_stop_done_at", 64'(done_at), 64'd43);
    check_eq("two_stop_done_count", 64'(ndone), 64'd1);
    check_eq("two_stop_idle_after", 64'(busy2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
